vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Parametrised VGA timing generator; the next generation of `hvsync_generator`. Produces sync, blanking and pixel coordinates for any resolution and porch set, with a pixel-enable input for clocks faster than the pixel rate. It also produces line and frame event pulses and a free-running frame counter. Scene, player and animation logic consume these, so no logic needs to be clocked on `vsync` any more. Every output is registered and cycle-aligned with `hpos`/`vpos`.

## Interface
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync pulse width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `HSYNC_ACTIVE`, 1'b1: level of `hsync` during the sync pulse
- `VSYNC_ACTIVE`, 1'b1: level of `vsync` during the sync pulse
- `COORD_W`, 10: width of `hpos`/`vpos`; must satisfy 2^COORD_W ≥ max(H_TOTAL, V_TOTAL)
- `FRAME_W`, 8: width of `frame_count`
- `clk  in  1`: the only clock; all state updates on its rising edge
- `reset  in  1`: synchronous, active-high reset
- `pix_en  in  1`: pixel strobe; counters advance only on edges where it is 1
- `hsync  out  1`: horizontal sync
- `vsync  out  1`: vertical sync
- `display_on  out  1`: high while the current pixel is in the visible area
- `hpos  out  COORD_W`: current column
- `vpos  out  COORD_W`: current row
- `line_tick  out  1`: one-clk pulse at the start of each line
- `frame_tick  out  1`: one-clk pulse at the start of vertical blanking
- `frame_count  out  FRAME_W`: completed-frame counter; wraps

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK
- Elaboration must fail if the `COORD_W` constraint is violated, or if any porch or sync parameter is 0.
- Advance: on an edge with `pix_en`=1:
  - `hpos` wraps from H_TOTAL−1 to 0, otherwise increments.
  - `vpos` changes only when `hpos` wraps: V_TOTAL−1 → 0, otherwise +1.
- Decoded outputs are computed from the *next* position and registered on the same edge, so they always describe the `hpos`/`vpos` currently presented:
  - `hsync` = HSYNC_ACTIVE iff H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC.
  - `vsync` = VSYNC_ACTIVE iff V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC.
  - `display_on` = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- `line_tick` is 1 for the single clk cycle after an advancing edge that moves `hpos` to 0.
- `frame_tick` is 1 for the single clk cycle after an advancing edge that moves the position to (hpos=0, vpos=V_DISPLAY).
- `frame_count` increments, modulo 2^FRAME_W, on that same edge.
- `pix_en`=0 holds all counters and decoded levels; `line_tick` and `frame_tick` drop to 0 on that edge. Tick pulse width is therefore exactly one clk, independent of the `pix_en` duty cycle.
- No other state; no FSM beyond the two counters.

## Timing
- Reset has priority over `pix_en`. On any edge with `reset`=1:
  - hpos=0, vpos=0, display_on=1
  - hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE
  - line_tick=0, frame_tick=0, frame_count=0
- Reset mid-frame takes effect on the next edge. The first advance after release moves the position to (1,0).
- No tick fires on reset release.
- Latency is zero: all outputs are mutually aligned. There is no one-cycle sync skew against the positions, unlike the previous generator.
- With `pix_en` tied to 1:
  - line period = H_TOTAL clk
  - frame period = H_TOTAL·V_TOTAL clk
- Simultaneous wrap of both counters, (H_TOTAL−1, V_TOTAL−1) → (0,0), produces `line_tick` only.
- `frame_tick` always coincides with a `line_tick`.

## Test plan
1. Reset values: hold `reset` 3 cycles with `pix_en`=1 → hpos=0, vpos=0, display_on=1, hsync=0, vsync=0, ticks 0, frame_count=0. Release → next edge gives hpos=1.
2. Default parameters, `pix_en`=1, one frame (420000 clk):
   - `hsync`=1 exactly while hpos ∈ [656,751].
   - `vsync`=1 exactly while vpos ∈ {490,491}.
   - display_on=0 at hpos=640 and at vpos=480.
   - `line_tick` count = 525; `frame_tick` count = 1, seen with hpos=0, vpos=480.
   - frame_count=1 afterwards.
3. `pix_en` toggling 1,0,1,0…: line period 1600 clk, frame period 840000 clk; every tick exactly one clk wide.
4. Small-configuration checks:
   - Parameters: H 4/1/2/1, V 3/1/1/1, HSYNC_ACTIVE=0, VSYNC_ACTIVE=0, FRAME_W=2, COORD_W=4.
   - H_TOTAL=8 and V_TOTAL=6, so the frame is 48 clk.
   - hsync=0 only at hpos 5,6; vsync=0 only at vpos 4.
   - frame_count reads 1,2,3,0 after frames 1–4.
5. Reset mid-frame: assert at hpos=300, vpos=200 with frame_count=5 → next edge gives all reset values. Then 420000 clk → exactly one `frame_tick`, at position (0,480).
6. Alignment check at every cycle of test 2: each output equals the decode of the currently presented `hpos`/`vpos`.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator.
//
// Two free-running position counters (hpos across the line, vpos down the
// frame) that advance on clk edges where pix_en is high. Sync, blanking and
// tick outputs are decoded from the position the counters are about to take
// and registered on the same edge, so every output is aligned with the
// hpos/vpos currently presented.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high; has priority over pix_en
//   pix_en       - pixel strobe; counters advance only when high
//   hsync        - horizontal sync, HSYNC_ACTIVE during the pulse
//   vsync        - vertical sync, VSYNC_ACTIVE during the pulse
//   display_on   - current pixel is in the visible area
//   hpos, vpos   - current column / row
//   line_tick    - one-clk pulse when a new line starts (hpos becomes 0)
//   frame_tick   - one-clk pulse when vertical blanking starts
//   frame_count  - completed-frame counter, wraps

module vga_sync_gen #(
    parameter int   H_DISPLAY    = 640,
    parameter int   H_FRONT      = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BACK       = 48,
    parameter int   V_DISPLAY    = 480,
    parameter int   V_FRONT      = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BACK       = 33,
    parameter logic HSYNC_ACTIVE = 1'b1,
    parameter logic VSYNC_ACTIVE = 1'b1,
    parameter int   COORD_W      = 10,
    parameter int   FRAME_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos,
    output logic               line_tick,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if ((2 ** COORD_W) < H_TOTAL || (2 ** COORD_W) < V_TOTAL) begin : g_bad_coord_w
        $error("vga_sync_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
        $error("vga_sync_gen: porch and sync widths must be non-zero");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic               h_wrap;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic               frame_start;

    // Next position if this edge advances; decoded outputs use it so that
    // they land in the same cycle as the position they describe.
    always_comb begin
        h_wrap = (hpos == H_LAST);
        h_next = h_wrap ? '0 : hpos + COORD_W'(1);
        v_next = vpos;
        if (h_wrap) begin
            v_next = (vpos == V_LAST) ? '0 : vpos + COORD_W'(1);
        end
        frame_start = h_wrap && (v_next == V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~HSYNC_ACTIVE;
            vsync       <= ~VSYNC_ACTIVE;
            display_on  <= 1'b1;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else if (pix_en) begin
            hpos        <= h_next;
            vpos        <= v_next;
            hsync       <= ((h_next >= HS_START) && (h_next < HS_END)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vsync       <= ((v_next >= VS_START) && (v_next < VS_END)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            display_on  <= (h_next < H_VIS) && (v_next < V_VIS);
            line_tick   <= h_wrap;
            frame_tick  <= frame_start;
            if (frame_start) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end else begin
            // Ticks last one clk regardless of the pix_en duty cycle.
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    // Instance 0: tiny config with active-low syncs. Instance 1: mid-size.
    localparam int HD [2] = '{4, 20};
    localparam int HF [2] = '{1, 3};
    localparam int HS [2] = '{2, 5};
    localparam int HB [2] = '{1, 4};
    localparam int VD [2] = '{3, 12};
    localparam int VF [2] = '{1, 2};
    localparam int VS [2] = '{1, 3};
    localparam int VB [2] = '{1, 2};
    localparam bit HA [2] = '{1'b0, 1'b1};
    localparam bit VA [2] = '{1'b0, 1'b1};
    localparam int FM [2] = '{4, 16};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    logic       hs_a, vs_a, de_a, lt_a, ft_a;
    logic [3:0] h_a, v_a;
    logic [1:0] fc_a;
    logic       hs_b, vs_b, de_b, lt_b, ft_b;
    logic [5:0] h_b, v_b;
    logic [3:0] fc_b;

    vga_sync_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .COORD_W(4), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
        .hpos(h_a), .vpos(v_a), .line_tick(lt_a), .frame_tick(ft_a),
        .frame_count(fc_a)
    );

    vga_sync_gen #(
        .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
        .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1), .COORD_W(6), .FRAME_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
        .hpos(h_b), .vpos(v_b), .line_tick(lt_b), .frame_tick(ft_b),
        .frame_count(fc_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit lt;
        bit ft;
        int fc;
    } exp_t;

    typedef struct {
        bit r;
        bit e;
        int h;
        int v;
        bit hs;
        bit de;
        bit lt;
    } vec_t;

    int checks = 0;
    int errors = 0;
    exp_t m [2];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t act [2];

    int cyc = 0;
    int lt_cnt [2];
    int ft_cnt [2];
    int last_lt_b = -1, last_ft_b = -1;
    int lt_period_b = 0, ft_period_b = 0;
    int ft_bad_pos = 0;

    // Reference model: position advance and decode from the timing definitions.
    function automatic exp_t step(exp_t c, bit r, bit e, int k);
        exp_t n;
        int htot, vtot;
        n = c;
        htot = HD[k] + HF[k] + HS[k] + HB[k];
        vtot = VD[k] + VF[k] + VS[k] + VB[k];
        if (r) begin
            n = '{h:0, v:0, hs:~HA[k], vs:~VA[k], de:1'b1, lt:1'b0, ft:1'b0, fc:0};
        end else if (!e) begin
            n.lt = 1'b0;
            n.ft = 1'b0;
        end else begin
            n.h = (c.h + 1) % htot;
            if (n.h == 0) n.v = (c.v + 1) % vtot;
            n.hs = (n.h >= HD[k] + HF[k] && n.h < HD[k] + HF[k] + HS[k]) ? HA[k] : ~HA[k];
            n.vs = (n.v >= VD[k] + VF[k] && n.v < VD[k] + VF[k] + VS[k]) ? VA[k] : ~VA[k];
            n.de = (n.h < HD[k]) && (n.v < VD[k]);
            n.lt = (n.h == 0);
            n.ft = (n.h == 0) && (n.v == VD[k]);
            if (n.ft) n.fc = (c.fc + 1) % FM[k];
        end
        return n;
    endfunction

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, a, e);
        end
    endtask

    task automatic cmp(input int k, input exp_t a, input exp_t e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL sb%0d cyc=%0d actual h=%0d v=%0d hs=%0b vs=%0b de=%0b lt=%0b ft=%0b fc=%0d expected h=%0d v=%0d hs=%0b vs=%0b de=%0b lt=%0b ft=%0b fc=%0d",
                     k, cyc, a.h, a.v, a.hs, a.vs, a.de, a.lt, a.ft, a.fc,
                     e.h, e.v, e.hs, e.vs, e.de, e.lt, e.ft, e.fc);
        end
    endtask

    // Drive one cycle, push model expectations, then pop and compare after the edge.
    task automatic cycle(input bit r, input bit e);
        exp_t ex;
        reset  = r;
        pix_en = e;
        m[0] = step(m[0], r, e, 0);
        m[1] = step(m[1], r, e, 1);
        q0.push_back(m[0]);
        q1.push_back(m[1]);
        @(posedge clk);
        #1;
        cyc++;
        act[0] = '{h:int'(h_a), v:int'(v_a), hs:hs_a, vs:vs_a, de:de_a, lt:lt_a, ft:ft_a, fc:int'(fc_a)};
        act[1] = '{h:int'(h_b), v:int'(v_b), hs:hs_b, vs:vs_b, de:de_b, lt:lt_b, ft:ft_b, fc:int'(fc_b)};
        if (q0.size() == 0 || q1.size() == 0) begin
            chk("sb_queue_empty", 1, 0);
        end else begin
            ex = q0.pop_front();
            cmp(0, act[0], ex);
            ex = q1.pop_front();
            cmp(1, act[1], ex);
        end
        for (int k = 0; k < 2; k++) begin
            if (act[k].lt) lt_cnt[k]++;
            if (act[k].ft) begin
                ft_cnt[k]++;
                if (act[k].h != 0 || act[k].v != VD[k]) ft_bad_pos++;
            end
        end
        if (lt_b) begin
            if (last_lt_b >= 0) lt_period_b = cyc - last_lt_b;
            last_lt_b = cyc;
        end
        if (ft_b) begin
            if (last_ft_b >= 0) ft_period_b = cyc - last_ft_b;
            last_ft_b = cyc;
        end
    endtask

    task automatic clear_stats();
        lt_cnt = '{0, 0};
        ft_cnt = '{0, 0};
        last_lt_b = -1;
        last_ft_b = -1;
        lt_period_b = 0;
        ft_period_b = 0;
        ft_bad_pos = 0;
    endtask

    vec_t tbl [14];

    initial begin
        // Hand-derived vectors for instance 0 (H_TOTAL=8, hsync low at 5,6).
        tbl[0]  = '{r:1, e:1, h:0, v:0, hs:1, de:1, lt:0};
        tbl[1]  = '{r:1, e:1, h:0, v:0, hs:1, de:1, lt:0};
        tbl[2]  = '{r:1, e:1, h:0, v:0, hs:1, de:1, lt:0};
        tbl[3]  = '{r:0, e:1, h:1, v:0, hs:1, de:1, lt:0};
        tbl[4]  = '{r:0, e:0, h:1, v:0, hs:1, de:1, lt:0};
        tbl[5]  = '{r:0, e:1, h:2, v:0, hs:1, de:1, lt:0};
        tbl[6]  = '{r:0, e:1, h:3, v:0, hs:1, de:1, lt:0};
        tbl[7]  = '{r:0, e:1, h:4, v:0, hs:1, de:0, lt:0};
        tbl[8]  = '{r:0, e:1, h:5, v:0, hs:0, de:0, lt:0};
        tbl[9]  = '{r:0, e:0, h:5, v:0, hs:0, de:0, lt:0};
        tbl[10] = '{r:0, e:1, h:6, v:0, hs:0, de:0, lt:0};
        tbl[11] = '{r:0, e:1, h:7, v:0, hs:1, de:0, lt:0};
        tbl[12] = '{r:0, e:1, h:0, v:1, hs:1, de:1, lt:1};
        tbl[13] = '{r:0, e:0, h:0, v:1, hs:1, de:1, lt:0};

        m[0] = '0;
        m[1] = '0;
        clear_stats();
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].r, tbl[i].e);
            checks++;
            if (int'(h_a) != tbl[i].h || int'(v_a) != tbl[i].v || hs_a != tbl[i].hs ||
                de_a != tbl[i].de || lt_a != tbl[i].lt) begin
                errors++;
                $display("FAIL vec%0d actual h=%0d v=%0d hs=%0b de=%0b lt=%0b expected h=%0d v=%0d hs=%0b de=%0b lt=%0b",
                         i, h_a, v_a, hs_a, de_a, lt_a, tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].de, tbl[i].lt);
            end
        end
        chk("reset_vsync_a", int'(vs_a), 1);
        chk("reset_vsync_b", int'(vs_b), 0);

        // Small config: frame_count after frames 1..4 reads 1,2,3,0.
        cycle(1, 1);
        for (int f = 1; f <= 4; f++) begin
            for (int i = 0; i < 48; i++) cycle(0, 1);
            chk($sformatf("small_fc_frame%0d", f), int'(fc_a), f % 4);
        end

        // Continuous pix_en: four frames of instance 1 (32x19 = 608 clk each).
        cycle(1, 1);
        clear_stats();
        for (int i = 0; i < 4 * 608; i++) cycle(0, 1);
        chk("cont_line_ticks", lt_cnt[1], 76);
        chk("cont_frame_ticks", ft_cnt[1], 4);
        chk("cont_line_period", lt_period_b, 32);
        chk("cont_frame_period", ft_period_b, 608);
        chk("cont_frame_count", int'(fc_b), 4);
        chk("cont_ft_position", ft_bad_pos, 0);

        // pix_en toggling 1,0: periods double, ticks stay one clk wide.
        cycle(1, 1);
        clear_stats();
        for (int i = 0; i < 2 * 608 * 2; i++) cycle(0, (i % 2) == 0);
        chk("tog_line_period", lt_period_b, 64);
        chk("tog_frame_period", ft_period_b, 1216);
        chk("tog_frame_ticks", ft_cnt[1], 2);

        // Mid-frame reset with a non-zero frame count.
        for (int i = 0; i < 2000 && !(m[1].h == 10 && m[1].v == 7); i++) cycle(0, 1);
        chk("mid_reached_pos", (int'(h_b) == 10 && int'(v_b) == 7) ? 1 : 0, 1);
        chk("mid_fc_nonzero", (fc_b != 0) ? 1 : 0, 1);
        cycle(1, 1);
        chk("mid_reset_h", int'(h_b), 0);
        chk("mid_reset_fc", int'(fc_b), 0);
        clear_stats();
        for (int i = 0; i < 608; i++) cycle(0, 1);
        chk("mid_one_frame_tick", ft_cnt[1], 1);
        chk("mid_ft_position", ft_bad_pos, 0);
        chk("mid_fc_after", int'(fc_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
